// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encoding,
// frame field sizes and the checksum fold used on every payload byte.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    // Frame layout: big-endian length header, payload, one checksum byte.
    localparam int HDR_LEN_BYTES  = 2;
    localparam int CSUM_LEN_BYTES = 1;
    localparam int LEN_W          = 8 * HDR_LEN_BYTES;
    localparam int CSUM_W         = 8 * CSUM_LEN_BYTES;

    function automatic logic [CSUM_W-1:0] csum_fold(
        input logic [CSUM_W-1:0] acc,
        input logic [7:0]        data
    );
        return acc ^ data;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream, writes the payload into instruction
// memory from address 0 and releases the CPU only once the checksum matches.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MEM_BYTES);

    state_e              state_q,      state_d;
    logic [LEN_W-1:0]    len_q,        len_d;
    logic [ADDR_W-1:0]   cnt_q,        cnt_d;
    logic [CSUM_W-1:0]   csum_q,       csum_d;
    logic                in_ready_q,   in_ready_d;
    logic                imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q,  imem_addr_d;
    logic [7:0]          imem_wdata_q, imem_wdata_d;
    logic                cpu_reset_q,  cpu_reset_d;
    logic                done_q,       done_d;
    logic                error_q,      error_d;

    logic                xfer_s;
    logic [LEN_W-1:0]    len_full_s;
    logic [LEN_W-1:0]    cnt_ext_s;
    logic                last_byte_s;

    assign xfer_s      = in_valid & in_ready_q;
    assign len_full_s  = {len_q[LEN_W-1:8], in_data};
    assign cnt_ext_s   = {{(LEN_W-ADDR_W){1'b0}}, cnt_q};
    // len_q >= 1 whenever DATA is active, so the subtraction cannot underflow there.
    assign last_byte_s = (cnt_ext_s == (len_q - {{(LEN_W-1){1'b0}}, 1'b1}));

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    len_d   = {LEN_W{1'b0}};
                    cnt_d   = {ADDR_W{1'b0}};
                    csum_d  = {CSUM_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN_HI: begin
                if (xfer_s) begin
                    len_d   = {in_data, 8'h00};
                    state_d = ST_LEN_LO;
                end else begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_LO: begin
                if (xfer_s) begin
                    len_d = len_full_s;
                    if (len_full_s > MAX_LEN) begin
                        state_d = ST_ERR;
                    end else if (len_full_s == {LEN_W{1'b0}}) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = cnt_q;
                    imem_wdata_d = in_data;
                    csum_d       = csum_fold(csum_q, in_data);
                    // Wraps only after the final byte of a full-size image; unused then.
                    cnt_d        = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (last_byte_s) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (xfer_s) begin
                    if (in_data == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_CSUM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs follow the state being entered, so they line up with state_q.
        case (state_d)
            ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM: in_ready_d = 1'b1;
            default:                                in_ready_d = 1'b0;
        endcase
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERR);
        cpu_reset_d = (state_d != ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            len_q        <= {LEN_W{1'b0}};
            cnt_q        <= {ADDR_W{1'b0}};
            csum_q       <= {CSUM_W{1'b0}};
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= {ADDR_W{1'b0}};
            imem_wdata_q <= 8'h00;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            csum_q       <= csum_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
